// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate unit: rotate, logical/arithmetic shift and rotate-through-carry,
// moving at most STEP bit positions per clock, with start/ready issue and a done pulse.
module shift_rotate_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [2:0]       mode,
    input  logic             carryIn,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       statusOut,
    output logic [1:0]       dbg_state_o
);

    localparam int LW = $clog2(WIDTH);
    localparam int AW = LW + 1;
    localparam logic [AW-1:0] STEP_A  = AW'(STEP);
    localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);

    localparam logic [2:0] MODE_ROL = 3'b000;
    localparam logic [2:0] MODE_ROR = 3'b001;
    localparam logic [2:0] MODE_SLL = 3'b010;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_SRA = 3'b100;
    localparam logic [2:0] MODE_RCL = 3'b101;
    localparam logic [2:0] MODE_RCR = 3'b110;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    // Handshake: an operation is accepted on a rising edge where start = 1 and ready = 1;
    // all operands are sampled at that edge and later input changes are ignored.
    // done is a one-cycle pulse; result/statusOut are valid from then until the next done.

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             c_q, c_d;
    logic             sign_q, sign_d;
    logic             ovf_en_q, ovf_en_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       status_q, status_d;
    logic             done_q, done_d;

    logic [AW-1:0]    amt_in;
    logic [AW-1:0]    step_s;
    logic [WIDTH-1:0] d_step;
    logic             c_step;
    logic             c_tmp;
    logic             accept;

    // ready stays low through the done cycle so back-to-back issue leaves one idle cycle
    assign ready       = (state_q == S_IDLE) && !done_q;
    assign busy        = (state_q == S_RUN) || (state_q == S_FIN);
    assign done        = done_q;
    assign result      = result_q;
    assign statusOut   = status_q;
    assign dbg_state_o = state_q;
    assign accept      = start && ready;

    always_comb begin
        amt_in = '0;
        case (mode)
            MODE_ROL, MODE_ROR, MODE_RCL, MODE_RCR:
                amt_in = {1'b0, operand2[LW-1:0]};
            MODE_SLL, MODE_SRL, MODE_SRA:
                amt_in = (|operand2[WIDTH-1:LW]) ? WIDTH_A : {1'b0, operand2[LW-1:0]};
            default:
                amt_in = '0;
        endcase
    end

    assign step_s = (rem_q > STEP_A) ? STEP_A : rem_q;

    // Up to STEP single-bit moves chained per cycle; bounds mux depth independent of WIDTH.
    always_comb begin
        d_step = data_q;
        c_step = c_q;
        c_tmp  = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (AW'(i) < step_s) begin
                c_tmp = c_step;
                case (mode_q)
                    MODE_ROL: begin
                        c_step = d_step[WIDTH-1];
                        d_step = {d_step[WIDTH-2:0], d_step[WIDTH-1]};
                    end
                    MODE_ROR: begin
                        c_step = d_step[0];
                        d_step = {d_step[0], d_step[WIDTH-1:1]};
                    end
                    MODE_SLL: begin
                        c_step = d_step[WIDTH-1];
                        d_step = {d_step[WIDTH-2:0], 1'b0};
                    end
                    MODE_SRL: begin
                        c_step = d_step[0];
                        d_step = {1'b0, d_step[WIDTH-1:1]};
                    end
                    MODE_SRA: begin
                        c_step = d_step[0];
                        d_step = {sign_q, d_step[WIDTH-1:1]};
                    end
                    MODE_RCL: begin
                        c_step = d_step[WIDTH-1];
                        d_step = {d_step[WIDTH-2:0], c_tmp};
                    end
                    MODE_RCR: begin
                        c_step = d_step[0];
                        d_step = {c_tmp, d_step[WIDTH-1:1]};
                    end
                    default: begin
                        c_step = c_tmp;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        c_d      = c_q;
        sign_d   = sign_q;
        ovf_en_d = ovf_en_q;
        result_d = result_q;
        status_d = status_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d   = operand1;
                    mode_d   = mode;
                    rem_d    = amt_in;
                    c_d      = ((mode == MODE_RCL) || (mode == MODE_RCR)) ? carryIn : 1'b0;
                    sign_d   = operand1[WIDTH-1];
                    ovf_en_d = (mode == MODE_SLL) && (amt_in != '0);
                    state_d  = (amt_in != '0) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                data_d = d_step;
                c_d    = c_step;
                rem_d  = rem_q - step_s;
                if (rem_q == step_s) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                result_d = data_q;
                status_d = {ovf_en_q && (data_q[WIDTH-1] != sign_q),
                            (data_q == '0),
                            data_q[WIDTH-1],
                            c_q};
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            rem_q    <= '0;
            mode_q   <= '0;
            c_q      <= 1'b0;
            sign_q   <= 1'b0;
            ovf_en_q <= 1'b0;
            result_q <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            c_q      <= c_d;
            sign_q   <= sign_d;
            ovf_en_q <= ovf_en_d;
            result_q <= result_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Bench for shift_rotate_seq: directed and random operations checked through an expected queue.
module tb_shift_rotate_seq;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [2:0]       mode;
    logic             carryIn;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       statusOut;
    logic [1:0]       dbg_state_o;

    // entry: {accept_cycle[15:0], latency[7:0], 4'b0, status[3:0], result[31:0]}
    logic [63:0] exp_q[$];
    logic [15:0] cyc;
    logic [31:0] last_res;
    int          tests_run;
    int          tests_failed;

    shift_rotate_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .operand1   (operand1),
        .operand2   (operand2),
        .mode       (mode),
        .carryIn    (carryIn),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .statusOut  (statusOut),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 16'd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] m, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci,
                                          input logic [15:0] acc);
        logic [31:0] r;
        logic        c;
        logic        ov;
        logic [32:0] v;
        logic [32:0] v2;
        int          amt;
        int          lat;
        r  = a;
        c  = 1'b0;
        ov = 1'b0;
        amt = 0;
        v  = {ci, a};
        case (m)
            3'b000: begin
                amt = int'(b % 32);
                r = (a << amt) | (a >> (32 - amt));
                c = (amt != 0) ? r[0] : 1'b0;
            end
            3'b001: begin
                amt = int'(b % 32);
                r = (a >> amt) | (a << (32 - amt));
                c = (amt != 0) ? r[31] : 1'b0;
            end
            3'b010, 3'b011, 3'b100: begin
                amt = (b >= 32) ? 32 : int'(b);
                if (m == 3'b010) begin
                    r = a << amt;
                    c = (amt != 0) ? a[32 - amt] : 1'b0;
                    ov = (amt != 0) && (r[31] != a[31]);
                end else begin
                    r = (m == 3'b011) ? (a >> amt) : 32'($signed(a) >>> amt);
                    c = (amt != 0) ? a[amt - 1] : 1'b0;
                end
            end
            3'b101, 3'b110: begin
                amt = int'(b % 32);
                if (m == 3'b101) v2 = (v << amt) | (v >> (33 - amt));
                else             v2 = (v >> amt) | (v << (33 - amt));
                r = v2[31:0];
                c = v2[32];
            end
            default: begin
                r = a;
            end
        endcase
        lat = 1 + (amt + STEP - 1) / STEP;
        return {acc, 8'(lat), 4'b0, {ov, (r == 32'd0), r[31], c}, r};
    endfunction

    // done monitor: pops the scoreboard and checks result, status and latency
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 64'(result), 64'(e[31:0]));
                check("status", 64'(statusOut), 64'(e[35:32]));
                check("latency", 64'(cyc - e[63:48]), 64'(e[47:40]));
                last_res = e[31:0];
            end
        end
    end

    // driver: called at a negedge; waits for ready, drives for one edge, then scrambles inputs
    task automatic issue(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input bit use_exp, input logic [31:0] er,
                         input logic [3:0] es, input logic [7:0] el);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 64'd0, 64'd1);
        start    = 1'b1;
        mode     = m;
        operand1 = a;
        operand2 = b;
        carryIn  = ci;
        if (use_exp) exp_q.push_back({cyc + 16'd1, el, 4'b0, es, er});
        else         exp_q.push_back(model(m, a, b, ci, cyc + 16'd1));
        @(negedge clk);
        start    = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        mode     = 3'($urandom_range(0, 7));
        carryIn  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ready && exp_q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!(ready && exp_q.size() == 0)) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] b;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 16'd0;
        last_res     = 32'd0;
        rst_n        = 1'b0;
        start        = 1'b0;
        operand1     = '0;
        operand2     = '0;
        mode         = '0;
        carryIn      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_status", 64'(statusOut), 64'd0);
        rst_n = 1'b1;

        // status = {ovf, zero, neg, carry}
        issue(3'b000, 32'h8000_0001, 32'd1,  1'b0, 1'b1, 32'h0000_0003, 4'b0001, 8'd2);
        issue(3'b001, 32'h0000_000F, 32'd36, 1'b0, 1'b1, 32'hF000_0000, 4'b0011, 8'd2);
        issue(3'b100, 32'h8000_0000, 32'd40, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0011, 8'd9);
        issue(3'b010, 32'h4000_0000, 32'd1,  1'b0, 1'b1, 32'h8000_0000, 4'b1010, 8'd2);
        issue(3'b011, 32'h0000_0001, 32'd32, 1'b0, 1'b1, 32'h0000_0000, 4'b0100, 8'd9);
        issue(3'b101, 32'h8000_0000, 32'd1,  1'b1, 1'b1, 32'h0000_0001, 4'b0001, 8'd2);
        issue(3'b110, 32'h1234_5678, 32'd0,  1'b0, 1'b1, 32'h1234_5678, 4'b0000, 8'd1);
        issue(3'b110, 32'h0000_0001, 32'd1,  1'b1, 1'b1, 32'h8000_0000, 4'b0011, 8'd2);
        issue(3'b111, 32'h8000_0000, 32'd5,  1'b1, 1'b1, 32'h8000_0000, 4'b0010, 8'd1);
        issue(3'b010, 32'h0000_0001, 32'd35, 1'b0, 1'b1, 32'h0000_0000, 4'b0101, 8'd9);
        issue(3'b000, 32'h0000_00A5, 32'd32, 1'b1, 1'b1, 32'h0000_00A5, 4'b0000, 8'd1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("result_hold", 64'(result), 64'(last_res));

        // start while busy must be ignored
        issue(3'b100, 32'h8000_0000, 32'd40, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0011, 8'd9);
        check("busy_in_run", 64'(busy), 64'd1);
        check("ready_in_run", 64'(ready), 64'd0);
        start    = 1'b1;
        mode     = 3'b000;
        operand1 = 32'h0000_1234;
        operand2 = 32'd0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset in the middle of RUN discards the operation
        issue(3'b011, 32'hDEAD_BEEF, 32'd32, 1'b0, 1'b1, 32'h0, 4'b0100, 8'd9);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_status", 64'(statusOut), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(3'b001, 32'h0000_0003, 32'd1, 1'b0, 1'b1, 32'h8000_0001, 4'b0011, 8'd2);
        wait_idle();

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            issue(3'($urandom_range(0, 7)), $urandom, b, 1'($urandom_range(0, 1)),
                  1'b0, 32'd0, 4'd0, 8'd0);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
